obuf_bias_sel_multi: RTL and testbench

Multi-channel, parametrised successor to the single-channel OBUF bias-select tracker. For NUM_CH output-buffer channels sharing one loop nest, it decides per channel whether the next tile takes its bias from OBUF (partial sum) or from the bias path. It also decides whether results go to DDR or PE, and generates the bias-switch block handshake. The block loop id is programmable instead of fixed, and a force mode is added. Sits between the loop controller and the OBUF/bias mux of each PE column group.

---
 rtl/obuf_bias_sel_multi.sv | 223 ++++++++++++++++++++++
 tb/tb_obuf_bias_sel_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obuf_bias_sel_multi.sv
// Multi-channel OBUF bias-select tracker: per-channel partial-sum vs bias-path select,
// DDR/PE routing and bias-switch block handshake, driven by a shared loop nest.

module obuf_bias_sel_ch #(
  parameter int LOOP_ID_W = 5,
  parameter int DEPTH     = 1 << LOOP_ID_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 busy,
  input  logic                 start,
  input  logic                 done,
  input  logic                 cfg_we,
  input  logic                 dep_wdata,
  input  logic [LOOP_ID_W-1:0] loop_id,
  input  logic [LOOP_ID_W-1:0] loop_index,
  input  logic                 loop_enter,
  input  logic                 loop_exit,
  input  logic                 loop_enter_dly,
  input  logic                 loop_exit_dly,
  input  logic                 loop_stall,
  input  logic                 loop_index_valid,
  input  logic                 loop_last_iter,
  input  logic                 blk_armed,
  input  logic                 sw_load_evt,
  input  logic                 compute_req,
  input  logic                 compute_done,
  output logic                 prev_bias,
  output logic                 ddr_pe_sw,
  output logic                 block
);

  logic [DEPTH-1:0] dep;
  logic [DEPTH-1:0] status;
  logic             sw_reg;
  logic             patch;
  logic             req_d1;
  logic [1:0]       cdone_pipe;
  logic             dep_cur;

  assign dep_cur = dep[loop_index];

  always_ff @(posedge clk) begin
    if (!reset) begin
      dep        <= '0;
      status     <= '0;
      prev_bias  <= 1'b0;
      ddr_pe_sw  <= 1'b1;
      sw_reg     <= 1'b0;
      block      <= 1'b0;
      patch      <= 1'b0;
      req_d1     <= 1'b0;
      cdone_pipe <= '0;
    end else begin
      if (cfg_we)
        dep[loop_id] <= dep_wdata;

      // status remembers the select a loop had when it was last left
      if (!busy)
        status[loop_id] <= 1'b0;
      else if (loop_enter_dly)
        status[loop_index] <= prev_bias;
      else if (loop_exit && !dep_cur)
        status[loop_index] <= 1'b1;

      if (!busy)
        prev_bias <= 1'b0;
      else if (loop_enter && loop_exit_dly)
        prev_bias <= status[loop_index];
      else if (loop_index_valid && !loop_stall && !dep_cur)
        prev_bias <= 1'b1;

      if (!busy)
        ddr_pe_sw <= 1'b1;
      else if ((loop_enter || loop_index_valid) && !dep_cur)
        ddr_pe_sw <= loop_last_iter;

      if (compute_done && prev_bias)
        sw_reg <= 1'b0;
      else if (blk_armed && sw_load_evt)
        sw_reg <= prev_bias;

      cdone_pipe <= {cdone_pipe[0], compute_done};
      req_d1     <= compute_req;

      if (cdone_pipe[1] && compute_req && blk_armed && !prev_bias)
        block <= 1'b1;
      else if (compute_req && !req_d1)
        block <= patch ? 1'b0 : sw_reg;

      // patch masks one stale block carried into the next layer's first request
      if (done)
        patch <= 1'b0;
      else if (start && block)
        patch <= 1'b1;
    end
  end

endmodule

module obuf_bias_sel_multi #(
  parameter int LOOP_ID_W     = 5,
  parameter int ADDR_STRIDE_W = 16,
  parameter int NUM_CH        = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            done,
  input  logic [NUM_CH*ADDR_STRIDE_W-1:0] obuf_stride,
  input  logic                            obuf_stride_v,
  input  logic [LOOP_ID_W-1:0]            cfg_block_loop_id,
  input  logic [1:0]                      cfg_force_mode,
  input  logic                            loop_last_iter,
  input  logic                            loop_stall,
  input  logic                            loop_enter,
  input  logic                            loop_exit,
  input  logic                            loop_index_valid,
  input  logic [LOOP_ID_W-1:0]            loop_index,
  input  logic [NUM_CH-1:0]               bias_sw_compute_req,
  input  logic [NUM_CH-1:0]               bias_sw_compute_done,
  output logic [NUM_CH-1:0]               bias_prev_sw,
  output logic [NUM_CH-1:0]               ddr_pe_sw,
  output logic [NUM_CH-1:0]               bias_prev_sw_block,
  output logic                            cfg_err
);

  localparam int                   DEPTH   = 1 << LOOP_ID_W;
  localparam logic [LOOP_ID_W-1:0] LID_MAX = '1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state;
  logic [LOOP_ID_W-1:0]   loop_id;
  logic                   loop_exit_dly;
  logic                   loop_enter_dly;
  logic                   last_d1;
  logic                   last_rise_dly;
  logic                   busy;
  logic                   cfg_we;
  logic                   blk_armed;
  logic                   sw_load_evt;
  logic [NUM_CH-1:0]      prev_bias;

  assign busy        = (state == BUSY);
  assign cfg_we      = obuf_stride_v && !done && (loop_id != LID_MAX);
  assign blk_armed   = (loop_id == cfg_block_loop_id);
  assign sw_load_evt = last_rise_dly || done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      loop_id        <= '0;
      cfg_err        <= 1'b0;
      loop_exit_dly  <= 1'b0;
      loop_enter_dly <= 1'b0;
      last_d1        <= 1'b0;
      last_rise_dly  <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) state <= BUSY;
        BUSY:    if (done)  state <= IDLE;
        default: state <= IDLE;
      endcase

      // the last table slot is never written; hitting it flags an overrun
      if (done) begin
        loop_id <= '0;
        cfg_err <= 1'b0;
      end else if (obuf_stride_v) begin
        if (loop_id == LID_MAX) cfg_err <= 1'b1;
        else                    loop_id <= loop_id + 1'b1;
      end

      loop_exit_dly  <= loop_exit;
      loop_enter_dly <= loop_enter;
      last_d1        <= loop_last_iter;
      last_rise_dly  <= loop_last_iter && !last_d1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    obuf_bias_sel_ch #(
      .LOOP_ID_W(LOOP_ID_W),
      .DEPTH    (DEPTH)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .busy            (busy),
      .start           (start),
      .done            (done),
      .cfg_we          (cfg_we),
      .dep_wdata       (|obuf_stride[c*ADDR_STRIDE_W +: ADDR_STRIDE_W]),
      .loop_id         (loop_id),
      .loop_index      (loop_index),
      .loop_enter      (loop_enter),
      .loop_exit       (loop_exit),
      .loop_enter_dly  (loop_enter_dly),
      .loop_exit_dly   (loop_exit_dly),
      .loop_stall      (loop_stall),
      .loop_index_valid(loop_index_valid),
      .loop_last_iter  (loop_last_iter),
      .blk_armed       (blk_armed),
      .sw_load_evt     (sw_load_evt),
      .compute_req     (bias_sw_compute_req[c]),
      .compute_done    (bias_sw_compute_done[c]),
      .prev_bias       (prev_bias[c]),
      .ddr_pe_sw       (ddr_pe_sw[c]),
      .block           (bias_prev_sw_block[c])
    );
  end

  // force overrides only what leaves the block; tracking state keeps running
  always_comb begin
    bias_prev_sw = prev_bias;
    case (cfg_force_mode)
      2'd1:    bias_prev_sw = '0;
      2'd2:    bias_prev_sw = '1;
      default: bias_prev_sw = prev_bias;
    endcase
  end

endmodule

// File: tb/tb_obuf_bias_sel_multi.sv
// Scoreboard bench for obuf_bias_sel_multi: expectations queued with stimulus, drained after each edge.

module tb_obuf_bias_sel_multi;

  localparam int LW = 5;
  localparam int SW = 16;
  localparam int NC = 2;

  localparam int S_BIAS = 0;
  localparam int S_DDR  = 1;
  localparam int S_BLK  = 2;
  localparam int S_ERR  = 3;
  localparam int S_LID  = 4;
  localparam int S_ST   = 5;

  logic             clk = 1'b0;
  logic             reset, start, done;
  logic [NC*SW-1:0] obuf_stride;
  logic             obuf_stride_v;
  logic [LW-1:0]    cfg_block_loop_id;
  logic [1:0]       cfg_force_mode;
  logic             loop_last_iter, loop_stall, loop_enter, loop_exit, loop_index_valid;
  logic [LW-1:0]    loop_index;
  logic [NC-1:0]    bias_sw_compute_req, bias_sw_compute_done;
  logic [NC-1:0]    bias_prev_sw, ddr_pe_sw, bias_prev_sw_block;
  logic             cfg_err;

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  obuf_bias_sel_multi #(.LOOP_ID_W(LW), .ADDR_STRIDE_W(SW), .NUM_CH(NC)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .done                (done),
    .obuf_stride         (obuf_stride),
    .obuf_stride_v       (obuf_stride_v),
    .cfg_block_loop_id   (cfg_block_loop_id),
    .cfg_force_mode      (cfg_force_mode),
    .loop_last_iter      (loop_last_iter),
    .loop_stall          (loop_stall),
    .loop_enter          (loop_enter),
    .loop_exit           (loop_exit),
    .loop_index_valid    (loop_index_valid),
    .loop_index          (loop_index),
    .bias_sw_compute_req (bias_sw_compute_req),
    .bias_sw_compute_done(bias_sw_compute_done),
    .bias_prev_sw        (bias_prev_sw),
    .ddr_pe_sw           (ddr_pe_sw),
    .bias_prev_sw_block  (bias_prev_sw_block),
    .cfg_err             (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic expect_q(input string tag, input int sig, input int val);
    q.push_back('{tag, sig, val});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sig)
        S_BIAS:  got = 32'(bias_prev_sw);
        S_DDR:   got = 32'(ddr_pe_sw);
        S_BLK:   got = 32'(bias_prev_sw_block);
        S_ERR:   got = 32'(cfg_err);
        S_LID:   got = 32'(dut.loop_id);
        default: got = 32'(dut.state);
      endcase
      chk(e.tag, got, 32'(e.val));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  logic [SW-1:0] strides [5];

  initial begin
    strides = '{16'd0, 16'd4, 16'd0, 16'd8, 16'd1};
    reset = 1'b0; start = 1'b1; done = 1'b0;
    obuf_stride = '0; obuf_stride_v = 1'b0;
    cfg_block_loop_id = 5'd31; cfg_force_mode = 2'd0;
    loop_last_iter = 1'b0; loop_stall = 1'b0; loop_enter = 1'b0;
    loop_exit = 1'b0; loop_index_valid = 1'b0; loop_index = '0;
    bias_sw_compute_req = '0; bias_sw_compute_done = '0;

    // reset held with start asserted
    tick(); tick();
    expect_q("rst_bias", S_BIAS, 0); expect_q("rst_ddr", S_DDR, 3);
    expect_q("rst_blk", S_BLK, 0);   expect_q("rst_err", S_ERR, 0);
    expect_q("rst_state", S_ST, 0);
    tick();
    reset = 1'b1; start = 1'b0;

    // configure 5 loops: ch0 strides {0,4,0,8,1}, ch1 all zero
    for (int i = 0; i < 5; i++) begin
      obuf_stride = {16'h0, strides[i]}; obuf_stride_v = 1'b1;
      tick();
    end
    obuf_stride_v = 1'b0; obuf_stride = '0;
    expect_q("cfg_lid5", S_LID, 5);
    tick();

    start = 1'b1;
    expect_q("start_bias0", S_BIAS, 0);
    tick();
    start = 1'b0;

    loop_index = 5'd0; loop_index_valid = 1'b1;
    expect_q("l0_bias", S_BIAS, 3); expect_q("l0_ddr", S_DDR, 0);
    tick();

    loop_enter = 1'b1; loop_index = 5'd2; loop_last_iter = 1'b0;
    expect_q("l2_ddr_last0", S_DDR, 0); expect_q("l2_bias", S_BIAS, 3);
    tick();
    loop_last_iter = 1'b1;
    expect_q("l2_ddr_last1", S_DDR, 3);
    tick();

    // loop 1 has ch0 dependency: ch0 holds, ch1 follows last_iter
    loop_enter = 1'b0; loop_index = 5'd1; loop_last_iter = 1'b0;
    expect_q("l1_ddr_dep", S_DDR, 1);
    tick();
    loop_index_valid = 1'b0;

    done = 1'b1;
    tick();
    done = 1'b0;
    expect_q("done_bias", S_BIAS, 0); expect_q("done_ddr", S_DDR, 3);
    expect_q("done_err", S_ERR, 0);   expect_q("done_lid", S_LID, 0);
    expect_q("done_state", S_ST, 0);
    tick();

    cfg_force_mode = 2'd2; expect_q("force2_idle", S_BIAS, 3); settle();
    cfg_force_mode = 2'd1; expect_q("force1_idle", S_BIAS, 0); settle();
    cfg_force_mode = 2'd3; expect_q("force3_idle", S_BIAS, 0); settle();
    cfg_force_mode = 2'd0;

    // block handshake armed at loop_id 3
    obuf_stride = '0; obuf_stride_v = 1'b1;
    repeat (3) tick();
    obuf_stride_v = 1'b0;
    cfg_block_loop_id = 5'd3;
    start = 1'b1; tick(); start = 1'b0;
    loop_index = 5'd0; loop_index_valid = 1'b1;
    expect_q("blk_bias", S_BIAS, 3);
    tick();
    loop_index_valid = 1'b0;
    cfg_force_mode = 2'd1; expect_q("force1_busy", S_BIAS, 0); settle();
    cfg_force_mode = 2'd0; expect_q("force0_busy", S_BIAS, 3); settle();

    loop_last_iter = 1'b1; tick(); loop_last_iter = 1'b0; tick();
    bias_sw_compute_req = 2'b11;
    expect_q("blk_load_lid3", S_BLK, 3);
    tick();

    bias_sw_compute_done = 2'b11; tick();
    bias_sw_compute_done = 2'b00; bias_sw_compute_req = 2'b00; tick();
    obuf_stride_v = 1'b1; tick(); obuf_stride_v = 1'b0;
    loop_last_iter = 1'b1; tick(); loop_last_iter = 1'b0; tick();
    bias_sw_compute_req = 2'b11;
    expect_q("blk_noload_lid4", S_BLK, 0);
    tick();
    bias_sw_compute_req = 2'b00; tick();

    // patch: block high when the next layer starts
    cfg_block_loop_id = 5'd4;
    loop_last_iter = 1'b1; tick(); loop_last_iter = 1'b0; tick();
    bias_sw_compute_req = 2'b11;
    expect_q("blk_rearm", S_BLK, 3);
    tick();
    bias_sw_compute_req = 2'b00; tick();
    done = 1'b1; tick(); done = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    bias_sw_compute_req = 2'b11;
    expect_q("patch_blk0", S_BLK, 0);
    tick();
    bias_sw_compute_req = 2'b00; tick();
    done = 1'b1; tick(); done = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    bias_sw_compute_req = 2'b11;
    expect_q("nopatch_blk", S_BLK, 3);
    tick();
    bias_sw_compute_req = 2'b00; tick();

    // config overrun
    obuf_stride_v = 1'b1;
    repeat (30) tick();
    expect_q("ovf31_lid", S_LID, 31); expect_q("ovf31_err", S_ERR, 0);
    tick();
    expect_q("ovf32_lid", S_LID, 31); expect_q("ovf32_err", S_ERR, 1);
    tick();
    expect_q("ovf33_lid", S_LID, 31); expect_q("ovf33_err", S_ERR, 1);
    tick();
    obuf_stride_v = 1'b0;
    done = 1'b1;
    expect_q("ovf_done_err", S_ERR, 0); expect_q("ovf_done_lid", S_LID, 0);
    tick();
    done = 1'b0;

    // reset in the middle of a layer
    start = 1'b1; tick(); start = 1'b0;
    loop_index = 5'd0; loop_index_valid = 1'b1;
    expect_q("mid_bias", S_BIAS, 3); expect_q("mid_ddr", S_DDR, 0);
    expect_q("mid_blk", S_BLK, 3);
    tick();
    reset = 1'b0;
    expect_q("mrst_bias", S_BIAS, 0); expect_q("mrst_ddr", S_DDR, 3);
    expect_q("mrst_blk", S_BLK, 0);   expect_q("mrst_err", S_ERR, 0);
    expect_q("mrst_state", S_ST, 0);
    tick();
    reset = 1'b1; loop_index_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
